seq_alu: RTL and testbench

Sequential execution unit sitting directly downstream of the ALU control decoder in the RISC-V datapath. Consumes the 4-bit ALU operation code plus two operands, executes arithmetic/logic ops in one cycle and shifts iteratively (1 bit/cycle), and reports completion with a one-cycle done pulse. Lets the multicycle control FSM stall on `busy_o` instead of paying for a barrel shifter.

---
 rtl/seq_alu_if.sv | 36 +++
 rtl/seq_alu.sv | 158 +++++++++++++++
 tb/tb_seq_alu.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// ---------------------------------------------------------------------------
// seq_alu_if
//   Request/response bundle between the multicycle control FSM (master) and
//   the sequential execution unit seq_alu (slave).
//
//   Signals:
//     start_i          master -> slave  request strobe
//     ALU_Operation_i  master -> slave  4-bit operation code
//     A_i, B_i         master -> slave  operands (shift amount is B_i[4:0])
//     busy_o           slave -> master  iterative shift in progress
//     done_o           slave -> master  one-cycle completion pulse
//     ALU_Result_o     slave -> master  registered result
//     Zero_o           slave -> master  registered (result == 0) flag
// ---------------------------------------------------------------------------
interface seq_alu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic [3:0]            ALU_Operation_i;
    logic [DATA_WIDTH-1:0] A_i;
    logic [DATA_WIDTH-1:0] B_i;
    logic                  busy_o;
    logic                  done_o;
    logic [DATA_WIDTH-1:0] ALU_Result_o;
    logic                  Zero_o;

    modport master (
        output start_i, ALU_Operation_i, A_i, B_i,
        input  busy_o, done_o, ALU_Result_o, Zero_o
    );

    modport slave (
        input  start_i, ALU_Operation_i, A_i, B_i,
        output busy_o, done_o, ALU_Result_o, Zero_o
    );
endinterface

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu
//   Sequential execution unit. Arithmetic/logic ops finish in one cycle;
//   shifts run one bit per cycle so the control FSM can stall on busy_o
//   instead of the datapath carrying a barrel shifter.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    seq_alu_if.slave (start/opcode/operands in, busy/done/result out)
//
//   Configuration macro:
//     SEQ_ALU_FAST_SHIFT_EN  when defined, shifts use a combinational barrel
//                            shifter, every op has latency 1, the SHIFT state
//                            and counter are not built and busy_o is tied 0.
// ---------------------------------------------------------------------------
module seq_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    seq_alu_if.slave bus
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_SRL = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_LUI = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_SLL = 4'b1100;

`ifdef SEQ_ALU_FAST_SHIFT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t                state_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q;
    logic                  done_q;

    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] alu_result_d;

    assign shamt = bus.B_i[4:0];

`ifndef SEQ_ALU_FAST_SHIFT_EN
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [4:0]            count_q;
    logic                  dir_right_q;
    logic                  busy_q;
    logic                  is_shift_d;
    logic [DATA_WIDTH-1:0] shift_next_d;

    assign shift_next_d = dir_right_q ? (shreg_q >> 1) : (shreg_q << 1);
`endif

    // Single-cycle result for the opcode currently on the bus. In the
    // iterative build a shift only uses this value when shamt is 0 (result A).
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a value unassigned and infer a latch.
        alu_result_d = '0;
`ifndef SEQ_ALU_FAST_SHIFT_EN
        is_shift_d   = 1'b0;
`endif
        case (bus.ALU_Operation_i)
            OP_ADD: alu_result_d = bus.A_i + bus.B_i;
            OP_SUB: alu_result_d = bus.A_i - bus.B_i;
            OP_AND: alu_result_d = bus.A_i & bus.B_i;
            OP_XOR: alu_result_d = bus.A_i ^ bus.B_i;
            OP_OR:  alu_result_d = bus.A_i | bus.B_i;
            OP_LUI: alu_result_d = bus.B_i;
`ifdef SEQ_ALU_FAST_SHIFT_EN
            OP_SLL: alu_result_d = bus.A_i << shamt;
            OP_SRL: alu_result_d = bus.A_i >> shamt;
`else
            OP_SLL, OP_SRL: begin
                alu_result_d = bus.A_i;
                is_shift_d   = 1'b1;
            end
`endif
            default: alu_result_d = '0;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            done_q      <= 1'b0;
`ifndef SEQ_ALU_FAST_SHIFT_EN
            shreg_q     <= '0;
            count_q     <= '0;
            dir_right_q <= 1'b0;
            busy_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
`ifndef SEQ_ALU_FAST_SHIFT_EN
                SHIFT: begin
                    // Inputs are ignored here; the op was latched at acceptance.
                    if (count_q == 5'd1) begin
                        result_q <= shift_next_d;
                        zero_q   <= (shift_next_d == '0);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        shreg_q  <= shift_next_d;
                        count_q  <= count_q - 5'd1;
                    end
                end
`endif
                default: begin
                    // IDLE and DONE both accept a new request.
                    if (bus.start_i) begin
`ifndef SEQ_ALU_FAST_SHIFT_EN
                        if (is_shift_d && (shamt != 5'd0)) begin
                            shreg_q     <= bus.A_i;
                            count_q     <= shamt;
                            dir_right_q <= (bus.ALU_Operation_i == OP_SRL);
                            busy_q      <= 1'b1;
                            done_q      <= 1'b0;
                            state_q     <= SHIFT;
                        end else
`endif
                        begin
                            result_q <= alu_result_d;
                            zero_q   <= (alu_result_d == '0);
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef SEQ_ALU_FAST_SHIFT_EN
    assign bus.busy_o = 1'b0;
`else
    assign bus.busy_o = busy_q;
`endif
    assign bus.done_o       = done_q;
    assign bus.ALU_Result_o = result_q;
    assign bus.Zero_o       = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu
//   Directed bench for seq_alu. A latency-countdown model derived from the
//   opcode table predicts busy/done/result/Zero every cycle; directed tests
//   also pin literal results, latencies and busy durations.
// ---------------------------------------------------------------------------
module tb_seq_alu;

`ifdef SEQ_ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    seq_alu_if #(.DATA_WIDTH(32)) bus ();

    seq_alu #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Opcode table expressed as plain arithmetic.
    function automatic logic [31:0] spec_result(input logic [3:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0100: return a ^ b;
            4'b1001: return a | b;
            4'b1000: return b;
            4'b1100: return a << sh;
            4'b0011: return a >> sh;
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- reference model ----------------
    // m_left counts cycles until the pending shift result is published.
    int          m_left   = 0;
    logic        m_done   = 1'b0;
    logic [31:0] m_result = '0;
    logic        m_zero   = 1'b0;
    logic [31:0] m_pend   = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left   <= 0;
            m_done   <= 1'b0;
            m_result <= '0;
            m_zero   <= 1'b0;
            m_pend   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done   <= 1'b1;
                    m_result <= m_pend;
                    m_zero   <= (m_pend == 32'h0);
                end
            end else if (bus.start_i) begin
                if (!FAST && (bus.ALU_Operation_i == 4'b1100 || bus.ALU_Operation_i == 4'b0011)
                    && bus.B_i[4:0] != 5'd0) begin
                    m_left <= int'(bus.B_i[4:0]);
                    m_pend <= spec_result(bus.ALU_Operation_i, bus.A_i, bus.B_i);
                end else begin
                    m_done   <= 1'b1;
                    m_result <= spec_result(bus.ALU_Operation_i, bus.A_i, bus.B_i);
                    m_zero   <= (spec_result(bus.ALU_Operation_i, bus.A_i, bus.B_i) == 32'h0);
                end
            end
        end
    end

    // Every-cycle comparison against the model, sampled away from the edge.
    always @(negedge clk) begin
        check("cyc_busy",   {31'b0, bus.busy_o}, {31'b0, (m_left != 0)});
        check("cyc_done",   {31'b0, bus.done_o}, {31'b0, m_done});
        check("cyc_result", bus.ALU_Result_o,    m_result);
        check("cyc_zero",   {31'b0, bus.Zero_o}, {31'b0, m_zero});
        if (bus.busy_o && bus.done_o)
            check("busy_and_done", 32'd1, 32'd0);
    end

    // ---------------- stimulus ----------------
    // Issue one op at a negedge and wait (bounded) for done_o; checks literal
    // result, Zero, latency and number of busy cycles.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int exp_busy);
        int lat;
        int busy_cnt;
        bus.ALU_Operation_i = op;
        bus.A_i             = a;
        bus.B_i             = b;
        bus.start_i         = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!bus.done_o && lat < 100) begin
            if (bus.busy_o) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_busy"}, busy_cnt, exp_busy);
        check({name, "_result"}, bus.ALU_Result_o, exp_res);
        check({name, "_zero"}, {31'b0, bus.Zero_o}, {31'b0, (exp_res == 32'h0)});
    endtask

    logic [3:0]  b2b_op  [4] = '{4'b1001, 4'b1000, 4'b0100, 4'b1111};
    logic [31:0] b2b_a   [4] = '{32'hF0, 32'h0, 32'hFF, 32'h1234};
    logic [31:0] b2b_b   [4] = '{32'h0F, 32'h12345000, 32'h0F, 32'h5678};
    logic [31:0] b2b_exp [4] = '{32'hFF, 32'h12345000, 32'hF0, 32'h0};

    initial begin
        int dcount;
        bus.start_i         = 1'b0;
        bus.ALU_Operation_i = 4'b0000;
        bus.A_i             = '0;
        bus.B_i             = '0;

        // Reset held for a few cycles with a request pending: nothing happens.
        bus.start_i = 1'b1;
        repeat (3) @(negedge clk);
        bus.start_i = 1'b0;
        check("rst_busy",   {31'b0, bus.busy_o}, 32'd0);
        check("rst_done",   {31'b0, bus.done_o}, 32'd0);
        check("rst_result", bus.ALU_Result_o,    32'd0);
        check("rst_zero",   {31'b0, bus.Zero_o}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("add_5_7",   4'b0000, 32'd5,        32'd7,  32'd12,        1, 0);
        run_op("sub_3_3",   4'b0001, 32'd3,        32'd3,  32'd0,         1, 0);
        run_op("sub_0_1",   4'b0001, 32'd0,        32'd1,  32'hFFFF_FFFF, 1, 0);
        run_op("add_wrap",  4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0,         1, 0);
        run_op("and",       4'b0010, 32'hF0F0,     32'hFF00, 32'hF000,    1, 0);
        run_op("sll_31",    4'b1100, 32'd1,        32'd31, 32'h8000_0000,
               FAST ? 1 : 32, FAST ? 0 : 31);
        run_op("srl_4",     4'b0011, 32'h8000_0000, 32'h24, 32'h0800_0000,
               FAST ? 1 : 5, FAST ? 0 : 4);
        run_op("sll_0",     4'b1100, 32'hABCD,     32'h0,  32'hABCD,      1, 0);

`ifndef SEQ_ALU_FAST_SHIFT_EN
        // Input changes and an extra start during a shift must be ignored.
        bus.ALU_Operation_i = 4'b1100;
        bus.A_i             = 32'h3;
        bus.B_i             = 32'h8;
        bus.start_i         = 1'b1;
        @(negedge clk);
        bus.ALU_Operation_i = 4'b0000;
        bus.A_i             = 32'hFFFF;
        bus.B_i             = 32'h0;
        repeat (2) @(negedge clk);
        bus.start_i = 1'b0;
        dcount = 3;
        while (!bus.done_o && dcount < 100) begin
            @(negedge clk);
            dcount++;
        end
        check("intf_latency", dcount, 9);
        check("intf_result", bus.ALU_Result_o, 32'h300);
        dcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done_o) dcount++;
        end
        check("intf_no_extra_done", dcount, 0);
`endif

        // Back-to-back single-cycle ops issued from DONE.
        for (int i = 0; i < 4; i++) begin
            bus.ALU_Operation_i = b2b_op[i];
            bus.A_i             = b2b_a[i];
            bus.B_i             = b2b_b[i];
            bus.start_i         = 1'b1;
            @(negedge clk);
            check("b2b_done",   {31'b0, bus.done_o}, 32'd1);
            check("b2b_result", bus.ALU_Result_o,    b2b_exp[i]);
        end
        bus.start_i = 1'b0;
        check("b2b_last_zero", {31'b0, bus.Zero_o}, 32'd1);
        @(negedge clk);
        check("b2b_done_drop", {31'b0, bus.done_o}, 32'd0);

        // Reset asserted four cycles into SRL shamt 10 (after a nonzero result).
        run_op("pre_abort", 4'b1001, 32'h1200, 32'h34, 32'h1234, 1, 0);
        bus.ALU_Operation_i = 4'b0011;
        bus.A_i             = 32'hFFFF_0000;
        bus.B_i             = 32'd10;
        bus.start_i         = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        dcount = bus.done_o ? 1 : 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done_o) dcount++;
        end
        #2 reset = 1'b0;
        #1;
        check("abort_busy",   {31'b0, bus.busy_o}, 32'd0);
        check("abort_done",   {31'b0, bus.done_o}, 32'd0);
        check("abort_result", bus.ALU_Result_o,    32'd0);
        check("abort_zero",   {31'b0, bus.Zero_o}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            if (bus.done_o) dcount++;
        end
        #2 reset = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (bus.done_o) dcount++;
        end
        check("abort_done_count", dcount, FAST ? 1 : 0);
        check("abort_result_after", bus.ALU_Result_o, 32'd0);

        run_op("post_abort_add", 4'b0000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1, 0);
        run_op("bad_op", 4'b0111, 32'h55, 32'hAA, 32'd0, 1, 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
